game_ctrl_multi: RTL and testbench
==================================

Name: game_ctrl_multi

Overview:
- Parametrised successor to the single-enemy game controller.
- Performs per-pixel collision detection between the player, the bullet layer and N_ENEMY enemy layers, with one-pulse-per-frame hit reporting.
- Keeps score, lives and post-hit invincibility, and runs the IDLE/RUN/OVER game state machine.
- Sits between the sprite generators (alpha outputs) and the enemy/bullet modules (crash inputs) in the VGA clock domain.

Parameters:
- N_ENEMY, 4: number of enemy channels.
- LIVES, 3: lives loaded on game start (1..7).
- SCORE_WIDTH, 16: score counter width.
- SCORE_PER_HIT, 10: points per destroyed enemy.
- INVINC_FRAMES, 120: frames of invincibility after losing a life.
- OVER_FRAMES, 180: frames spent in OVER before returning to IDLE.

Ports:
- clk_vga  in  1  pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- disp_i  in  1  active display region; collisions are counted only when high.
- v_sync_i  in  1  VGA vertical sync (active-low); its falling edge is the frame tick.
- gamestart_i  in  1  start request, level-sensitive.
- me_alpha_i  in  1  player pixel opaque.
- bullet_alpha_i  in  1  bullet pixel opaque.
- enemy_alpha_i  in  N_ENEMY  per-enemy pixel opaque.
- game_status_o  out  2  00 IDLE, 01 RUN, 10 OVER.
- crash_me_enemy_o  out  N_ENEMY  per-enemy player-collision pulse.
- crash_enemy_bullet_o  out  N_ENEMY  per-enemy destroyed pulse.
- bomb_o  out  1  one-cycle pulse when any enemy is destroyed.
- invinc_o  out  1  player invincible.
- lives_o  out  3  remaining lives.
- score_o  out  SCORE_WIDTH  current score.

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; all pulses 0; invinc_o 0; lives_o 0; score_o 0.
  - Hit flags, frame counters and v_sync history register cleared (history reset to 1).
- Frame tick:
  - Internal; asserted one cycle when the registered v_sync_i is 1 and the current v_sync_i is 0.
  - On a tick, all per-frame hit flags (bullet flags and me flags) are cleared.
  - An overlap in the same cycle as a tick counts for the new frame: the clear happens first, then the set.
- State IDLE:
  - No pulses, score frozen.
  - When gamestart_i is high: go to RUN next cycle, load lives_o=LIVES, clear score_o to 0, clear invinc_o.
- Bullet hit, RUN only:
  - raw_b[i] = disp_i & bullet_alpha_i & enemy_alpha_i[i].
  - If raw_b[i] is set and bflag[i] is clear: set bflag[i] and pulse crash_enemy_bullet_o[i] for one cycle.
  - Registered: the pulse appears 1 cycle after the overlapping pixel.
  - bomb_o is the OR of the pulsing bits, same cycle.
  - score_o += popcount(pulsing bits) * SCORE_PER_HIT, and saturates at 2^SCORE_WIDTH-1.
- Player hit, RUN only, and only while invinc_o is 0:
  - raw_m[i] = disp_i & me_alpha_i & enemy_alpha_i[i].
  - First overlap per frame per enemy pulses crash_me_enemy_o[i] one cycle later.
  - On the first pulse cycle of a frame (any bits): lives_o decrements by exactly 1, even if several enemies hit.
  - If lives_o was 1: lives_o becomes 0 and the state goes to OVER.
  - Otherwise: invinc_o is set and the invincibility counter loads INVINC_FRAMES.
- Invincibility:
  - The counter decrements on each frame tick.
  - invinc_o clears on the tick where the counter reaches 0.
  - While invinc_o is high, crash_me_enemy_o stays 0; bullet hits still work.
- Simultaneous bullet and player hit on the same enemy in the same cycle: both pulses fire.
- State OVER:
  - All pulses 0; score held; the over counter loads OVER_FRAMES on entry and decrements per tick.
  - At 0: go to IDLE, with lives_o and score_o held until the next start.
  - gamestart_i is ignored in OVER.
- In IDLE and OVER the hit flags are still cleared on ticks, and no flags are set.
- Reset mid-game: immediate return to the reset values, with no pulses emitted.

Test Plan:
- Reset, then gamestart_i=1 for 1 cycle -> game_status_o=01, lives_o=3, score_o=0 on the next cycle.
- RUN, enemy 2 overlaps the bullet for 5 consecutive pixels in one frame -> exactly one crash_enemy_bullet_o=4'b0100 pulse and one bomb_o pulse; score_o=10. After the next tick a repeat overlap gives score_o=20.
- Enemies 0 and 3 hit by the bullet in the same cycle -> crash_enemy_bullet_o=4'b1001, a single-cycle bomb_o, score_o increases by 20.
- Player overlaps enemies 1 and 2 in one frame -> lives_o 3→2 (once), invinc_o=1, both crash_me_enemy_o bits pulse. Further overlaps during the next 120 ticks -> no pulses, lives_o stays 2. invinc_o clears after the 120th tick.
- Lives at 1, player hit -> lives_o=0, game_status_o=10. After 180 ticks -> 00. gamestart_i held high during OVER has no effect until IDLE, then starts a new game with score_o=0.
- Score preset near max (SCORE_WIDTH=4 build) with repeated hits -> score_o saturates at 15. Async rst asserted mid-frame -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/game_ctrl_multi_if.sv
// Sprite-side bundle for game_ctrl_multi: alpha/sync inputs and crash/status outputs.
// The controller uses the slave modport; the sprite/enemy side uses the master modport.
interface game_ctrl_multi_if #(
    parameter int N_ENEMY     = 4,
    parameter int SCORE_WIDTH = 16
);
    logic                   disp_i;
    logic                   v_sync_i;
    logic                   gamestart_i;
    logic                   me_alpha_i;
    logic                   bullet_alpha_i;
    logic [N_ENEMY-1:0]     enemy_alpha_i;
    logic [1:0]             game_status_o;
    logic [N_ENEMY-1:0]     crash_me_enemy_o;
    logic [N_ENEMY-1:0]     crash_enemy_bullet_o;
    logic                   bomb_o;
    logic                   invinc_o;
    logic [2:0]             lives_o;
    logic [SCORE_WIDTH-1:0] score_o;

    modport master (
        output disp_i, v_sync_i, gamestart_i, me_alpha_i, bullet_alpha_i, enemy_alpha_i,
        input  game_status_o, crash_me_enemy_o, crash_enemy_bullet_o, bomb_o, invinc_o,
               lives_o, score_o
    );

    modport slave (
        input  disp_i, v_sync_i, gamestart_i, me_alpha_i, bullet_alpha_i, enemy_alpha_i,
        output game_status_o, crash_me_enemy_o, crash_enemy_bullet_o, bomb_o, invinc_o,
               lives_o, score_o
    );
endinterface

// File: rtl/game_ctrl_multi.sv
// Multi-enemy game controller: per-pixel collision detection with one pulse per enemy per
// frame, saturating score, lives with post-hit invincibility, and the IDLE/RUN/OVER FSM.
module game_ctrl_multi #(
    parameter int N_ENEMY       = 4,
    parameter int LIVES         = 3,
    parameter int SCORE_WIDTH   = 16,
    parameter int SCORE_PER_HIT = 10,
    parameter int INVINC_FRAMES = 120,
    parameter int OVER_FRAMES   = 180
) (
    input logic              clk_vga,
    input logic              rst,
    game_ctrl_multi_if.slave bus
);
    localparam int HW    = $clog2(N_ENEMY + 1);
    localparam int PW    = $clog2(SCORE_PER_HIT + 1);
    localparam int SUM_W = SCORE_WIDTH + HW + PW + 1;
    localparam int IW    = $clog2(INVINC_FRAMES + 1);
    localparam int OW    = $clog2(OVER_FRAMES + 1);
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_WIDTH{1'b1}});

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    state_e                 state_q, state_d;
    logic                   vs_q, vs_d;
    logic [N_ENEMY-1:0]     bflag_q, bflag_d;
    logic [N_ENEMY-1:0]     mflag_q, mflag_d;
    logic [N_ENEMY-1:0]     crash_b_q, crash_b_d;
    logic [N_ENEMY-1:0]     crash_m_q, crash_m_d;
    logic                   bomb_q, bomb_d;
    logic                   invinc_q, invinc_d;
    logic [2:0]             lives_q, lives_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic [IW-1:0]          inv_cnt_q, inv_cnt_d;
    logic [OW-1:0]          over_cnt_q, over_cnt_d;

    logic                   tick;
    logic [N_ENEMY-1:0]     raw_b, raw_m, new_b, new_m;
    logic [HW-1:0]          hit_cnt;
    logic [SUM_W-1:0]       sum;

    assign tick  = vs_q & ~bus.v_sync_i;
    assign raw_b = {N_ENEMY{bus.disp_i & bus.bullet_alpha_i}} & bus.enemy_alpha_i;
    assign raw_m = {N_ENEMY{bus.disp_i & bus.me_alpha_i}} & bus.enemy_alpha_i;

    // Flags are cleared on the tick before any new hit is recorded, so an overlap on
    // the tick cycle belongs to the new frame.
    always_comb begin
        state_d    = state_q;
        vs_d       = bus.v_sync_i;
        bflag_d    = tick ? '0 : bflag_q;
        mflag_d    = tick ? '0 : mflag_q;
        crash_b_d  = '0;
        crash_m_d  = '0;
        bomb_d     = 1'b0;
        invinc_d   = invinc_q;
        lives_d    = lives_q;
        score_d    = score_q;
        inv_cnt_d  = inv_cnt_q;
        over_cnt_d = over_cnt_q;
        new_b      = '0;
        new_m      = '0;
        hit_cnt    = '0;
        sum        = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.gamestart_i) begin
                    state_d   = ST_RUN;
                    lives_d   = 3'(LIVES);
                    score_d   = '0;
                    invinc_d  = 1'b0;
                    inv_cnt_d = '0;
                end
            end
            ST_RUN: begin
                new_b     = raw_b & ~bflag_d;
                new_m     = invinc_q ? '0 : (raw_m & ~mflag_d);
                bflag_d   = bflag_d | new_b;
                mflag_d   = mflag_d | new_m;
                crash_b_d = new_b;
                crash_m_d = new_m;
                bomb_d    = |new_b;

                for (int i = 0; i < N_ENEMY; i++) begin
                    hit_cnt = hit_cnt + HW'(new_b[i]);
                end
                sum = SUM_W'(score_q) + SUM_W'(hit_cnt) * SUM_W'(SCORE_PER_HIT);
                score_d = (sum > SCORE_MAX) ? {SCORE_WIDTH{1'b1}} : sum[SCORE_WIDTH-1:0];

                if (invinc_q && tick) begin
                    if (inv_cnt_q <= IW'(1)) begin
                        invinc_d  = 1'b0;
                        inv_cnt_d = '0;
                    end else begin
                        inv_cnt_d = inv_cnt_q - IW'(1);
                    end
                end

                // Hits are only accepted while vulnerable and invincibility starts on the
                // same edge, so a frame can never cost more than one life.
                if (|new_m) begin
                    if (lives_q <= 3'd1) begin
                        lives_d    = 3'd0;
                        state_d    = ST_OVER;
                        over_cnt_d = OW'(OVER_FRAMES);
                    end else begin
                        lives_d   = lives_q - 3'd1;
                        invinc_d  = 1'b1;
                        inv_cnt_d = IW'(INVINC_FRAMES);
                    end
                end
            end
            ST_OVER: begin
                if (tick) begin
                    if (over_cnt_q <= OW'(1)) begin
                        state_d    = ST_IDLE;
                        over_cnt_d = '0;
                    end else begin
                        over_cnt_d = over_cnt_q - OW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            vs_q       <= 1'b1;
            bflag_q    <= '0;
            mflag_q    <= '0;
            crash_b_q  <= '0;
            crash_m_q  <= '0;
            bomb_q     <= 1'b0;
            invinc_q   <= 1'b0;
            lives_q    <= 3'd0;
            score_q    <= '0;
            inv_cnt_q  <= '0;
            over_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vs_d;
            bflag_q    <= bflag_d;
            mflag_q    <= mflag_d;
            crash_b_q  <= crash_b_d;
            crash_m_q  <= crash_m_d;
            bomb_q     <= bomb_d;
            invinc_q   <= invinc_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            inv_cnt_q  <= inv_cnt_d;
            over_cnt_q <= over_cnt_d;
        end
    end

    assign bus.game_status_o        = state_q;
    assign bus.crash_enemy_bullet_o = crash_b_q;
    assign bus.crash_me_enemy_o     = crash_m_q;
    assign bus.bomb_o               = bomb_q;
    assign bus.invinc_o             = invinc_q;
    assign bus.lives_o              = lives_q;
    assign bus.score_o              = score_q;
endmodule

// File: tb/tb_game_ctrl_multi.sv
// Directed bench for game_ctrl_multi: a default build plus a SCORE_WIDTH=4 build fed the
// same inputs to observe score saturation.
module tb_game_ctrl_multi;
    logic clk_vga = 1'b0;
    logic rst;
    int   checks;
    int   fails;
    logic [3:0] seen;

    always #5 clk_vga = ~clk_vga;

    game_ctrl_multi_if #(.N_ENEMY(4), .SCORE_WIDTH(16)) bus ();
    game_ctrl_multi_if #(.N_ENEMY(4), .SCORE_WIDTH(4))  bus4 ();

    assign bus4.disp_i         = bus.disp_i;
    assign bus4.v_sync_i       = bus.v_sync_i;
    assign bus4.gamestart_i    = bus.gamestart_i;
    assign bus4.me_alpha_i     = bus.me_alpha_i;
    assign bus4.bullet_alpha_i = bus.bullet_alpha_i;
    assign bus4.enemy_alpha_i  = bus.enemy_alpha_i;

    game_ctrl_multi #(
        .N_ENEMY(4), .LIVES(3), .SCORE_WIDTH(16), .SCORE_PER_HIT(10),
        .INVINC_FRAMES(120), .OVER_FRAMES(180)
    ) dut (
        .clk_vga (clk_vga),
        .rst     (rst),
        .bus     (bus)
    );

    game_ctrl_multi #(
        .N_ENEMY(4), .LIVES(3), .SCORE_WIDTH(4), .SCORE_PER_HIT(10),
        .INVINC_FRAMES(120), .OVER_FRAMES(180)
    ) dut4 (
        .clk_vga (clk_vga),
        .rst     (rst),
        .bus     (bus4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic disp, input logic me, input logic bullet,
                                 input logic [3:0] enemy, input logic start);
        bus.disp_i         = disp;
        bus.me_alpha_i     = me;
        bus.bullet_alpha_i = bullet;
        bus.enemy_alpha_i  = enemy;
        bus.gamestart_i    = start;
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk_vga);
        #1;
    endtask

    task automatic frameTick();
        bus.v_sync_i = 1'b0;
        cycle(1);
        bus.v_sync_i = 1'b1;
        cycle(1);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        seen   = 4'b0;
        rst    = 1'b0;
        bus.v_sync_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        #12;
        $display("[TB] reset values");
        checkOutput("rst_status", 32'(bus.game_status_o), 32'h0);
        checkOutput("rst_lives", 32'(bus.lives_o), 32'h0);
        checkOutput("rst_score", 32'(bus.score_o), 32'h0);
        checkOutput("rst_invinc", 32'(bus.invinc_o), 32'h0);
        checkOutput("rst_bomb", 32'(bus.bomb_o), 32'h0);
        rst = 1'b1;
        cycle(2);
        checkOutput("idle_status", 32'(bus.game_status_o), 32'h0);

        $display("[TB] game start");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        cycle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        checkOutput("start_status", 32'(bus.game_status_o), 32'h1);
        checkOutput("start_lives", 32'(bus.lives_o), 32'h3);
        checkOutput("start_score", 32'(bus.score_o), 32'h0);
        checkOutput("start_invinc", 32'(bus.invinc_o), 32'h0);

        $display("[TB] enemy 2 under bullet for 5 pixels");
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1);
            checkOutput("e2_crash_b", 32'(bus.crash_enemy_bullet_o), (i == 0) ? 32'h4 : 32'h0);
            checkOutput("e2_bomb", 32'(bus.bomb_o), (i == 0) ? 32'h1 : 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        cycle(1);
        checkOutput("e2_score", 32'(bus.score_o), 32'd10);
        checkOutput("e2_score_w4", 32'(bus4.score_o), 32'd10);

        frameTick();
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0100, 1'b0);
        cycle(1);
        checkOutput("e2_again_crash_b", 32'(bus.crash_enemy_bullet_o), 32'h4);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        cycle(1);
        checkOutput("e2_again_score", 32'(bus.score_o), 32'd20);
        checkOutput("sat_score_w4", 32'(bus4.score_o), 32'd15);

        $display("[TB] enemies 0 and 3 in the same cycle");
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b1001, 1'b0);
        cycle(1);
        checkOutput("e03_crash_b", 32'(bus.crash_enemy_bullet_o), 32'h9);
        checkOutput("e03_bomb", 32'(bus.bomb_o), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        cycle(1);
        checkOutput("e03_bomb_off", 32'(bus.bomb_o), 32'h0);
        checkOutput("e03_score", 32'(bus.score_o), 32'd40);
        checkOutput("e03_score_w4", 32'(bus4.score_o), 32'd15);

        $display("[TB] player hit by enemies 1 and 2");
        frameTick();
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0110, 1'b0);
        cycle(1);
        checkOutput("me12_crash_m", 32'(bus.crash_me_enemy_o), 32'h6);
        checkOutput("me12_crash_b", 32'(bus.crash_enemy_bullet_o), 32'h0);
        checkOutput("me12_lives", 32'(bus.lives_o), 32'h2);
        checkOutput("me12_invinc", 32'(bus.invinc_o), 32'h1);
        cycle(1);
        checkOutput("me12_hold_crash_m", 32'(bus.crash_me_enemy_o), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

        for (int k = 1; k <= 119; k++) begin
            frameTick();
            applyStimulus(1'b1, 1'b1, 1'b0, 4'b1111, 1'b0);
            cycle(1);
            seen = seen | bus.crash_me_enemy_o;
            applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        end
        checkOutput("invinc_no_pulse", 32'(seen), 32'h0);
        checkOutput("invinc_lives", 32'(bus.lives_o), 32'h2);
        checkOutput("invinc_119", 32'(bus.invinc_o), 32'h1);

        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0010, 1'b0);
        cycle(1);
        checkOutput("invinc_bullet", 32'(bus.crash_enemy_bullet_o), 32'h2);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        cycle(1);
        checkOutput("invinc_score", 32'(bus.score_o), 32'd50);
        frameTick();
        checkOutput("invinc_120", 32'(bus.invinc_o), 32'h0);

        $display("[TB] simultaneous bullet and player hit on enemy 0");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b0001, 1'b0);
        cycle(1);
        checkOutput("both_crash_m", 32'(bus.crash_me_enemy_o), 32'h1);
        checkOutput("both_crash_b", 32'(bus.crash_enemy_bullet_o), 32'h1);
        checkOutput("both_lives", 32'(bus.lives_o), 32'h1);
        checkOutput("both_invinc", 32'(bus.invinc_o), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        cycle(1);
        checkOutput("both_score", 32'(bus.score_o), 32'd60);

        repeat (120) frameTick();
        checkOutput("invinc2_off", 32'(bus.invinc_o), 32'h0);
        checkOutput("run_status", 32'(bus.game_status_o), 32'h1);

        $display("[TB] last life lost");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0100, 1'b0);
        cycle(1);
        checkOutput("over_crash_m", 32'(bus.crash_me_enemy_o), 32'h4);
        checkOutput("over_lives", 32'(bus.lives_o), 32'h0);
        checkOutput("over_status", 32'(bus.game_status_o), 32'h2);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        cycle(1);
        checkOutput("over_pulse_off", 32'(bus.crash_me_enemy_o), 32'h0);

        repeat (179) frameTick();
        checkOutput("over_179_status", 32'(bus.game_status_o), 32'h2);
        checkOutput("over_179_score", 32'(bus.score_o), 32'd60);
        bus.v_sync_i = 1'b0;
        cycle(1);
        checkOutput("over_180_status", 32'(bus.game_status_o), 32'h0);
        checkOutput("idle_lives_held", 32'(bus.lives_o), 32'h0);
        checkOutput("idle_score_held", 32'(bus.score_o), 32'd60);
        checkOutput("idle_score_held_w4", 32'(bus4.score_o), 32'd15);
        bus.v_sync_i = 1'b1;
        cycle(1);
        checkOutput("restart_status", 32'(bus.game_status_o), 32'h1);
        checkOutput("restart_lives", 32'(bus.lives_o), 32'h3);
        checkOutput("restart_score", 32'(bus.score_o), 32'h0);
        checkOutput("restart_score_w4", 32'(bus4.score_o), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0001, 1'b0);
        cycle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        checkOutput("pre_rst_crash_b", 32'(bus.crash_enemy_bullet_o), 32'h1);
        cycle(1);
        checkOutput("pre_rst_score", 32'(bus.score_o), 32'd10);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_status", 32'(bus.game_status_o), 32'h0);
        checkOutput("arst_lives", 32'(bus.lives_o), 32'h0);
        checkOutput("arst_score", 32'(bus.score_o), 32'h0);
        checkOutput("arst_invinc", 32'(bus.invinc_o), 32'h0);
        checkOutput("arst_bomb", 32'(bus.bomb_o), 32'h0);
        rst = 1'b1;
        cycle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
